// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch/countdown stage.
package stopwatch_pkg;

  localparam int FIELD_W   = 6;
  localparam int MAX_FIELD = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] minute;
    logic [FIELD_W-1:0] second;
  } packed_time_t;

  // Clamp a loaded minute/second field to the legal 0..59 range.
  function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] v);
    return (v > FIELD_W'(MAX_FIELD)) ? FIELD_W'(MAX_FIELD) : v;
  endfunction

endpackage

// File: rtl/stopwatch_counter_button_edge.sv
// Push-button conditioning: 2-flop synchronizer plus rising-edge detector.
// The edge pulse is built only from flops, so it is glitch-free.
module button_edge (
  input  logic hz100,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync0, sync1, prev, armed;

  // Synchronize the raw button, remember last level, and arm once the
  // button has been seen released (a press held through reset is ignored).
  always_ff @(posedge hz100) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      prev  <= sync1;
      // Arming only ever goes 0->1, so a marginal sample of the raw level
      // can at worst delay arming by one cycle.
      armed <= armed | ~btn;
    end
  end

  assign pulse = sync1 & ~prev & armed;

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch / countdown stage: 1 s time base plus up/down counter.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | counter and prescaler held, waiting for start
// RUNNING | prescaler advances, counter steps every tick
// PAUSED  | counter and prescaler frozen, resumes in place
// EXPIRED | countdown reached 00:00, waits for clear/load
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        mode,
  input  logic        load,
  input  logic [11:0] load_value,
  output logic [11:0] counter_out,
  output logic        running,
  output logic        expired,
  output logic        rollover
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [FIELD_W-1:0] FMAX = FIELD_W'(MAX_FIELD);

  sw_state_t    state, state_nxt;
  logic [PRE_W-1:0] pre;
  packed_time_t cnt, cnt_up, cnt_dn;
  logic         ss_ev, clr_ev, ld_ev;
  logic         load_ok, tick, down_done, wrap;

  button_edge u_ss  (.hz100(hz100), .reset(reset), .btn(start_stop), .pulse(ss_ev));
  button_edge u_clr (.hz100(hz100), .reset(reset), .btn(clear),      .pulse(clr_ev));
  button_edge u_ld  (.hz100(hz100), .reset(reset), .btn(load),       .pulse(ld_ev));

  assign load_ok   = ld_ev && ((state == IDLE) || (state == EXPIRED));
  assign tick      = (state == RUNNING) && (pre == PRE_LAST);
  // A down step expires both from 00:01 and when started at 00:00.
  assign down_done = (cnt.minute == '0) && (cnt.second <= FIELD_W'(1));

  // State register.
  always_ff @(posedge hz100) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, priority clear > load > start_stop > tick.
  always_comb begin
    state_nxt = state;
    if (clr_ev) begin
      state_nxt = IDLE;
    end else if (load_ok) begin
      state_nxt = IDLE;
    end else if (ss_ev) begin
      case (state)
        IDLE:    state_nxt = RUNNING;
        RUNNING: state_nxt = PAUSED;
        PAUSED:  state_nxt = RUNNING;
        default: state_nxt = state;
      endcase
    end else if (tick && mode && down_done) begin
      state_nxt = EXPIRED;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    running = (state == RUNNING);
  end

  // Candidate up and down steps of the mm:ss value.
  always_comb begin
    cnt_up = cnt;
    cnt_dn = cnt;
    wrap   = 1'b0;
    if (cnt.second == FMAX) begin
      cnt_up.second = '0;
      if (cnt.minute == FMAX) begin
        cnt_up.minute = '0;
        wrap          = 1'b1;
      end else begin
        cnt_up.minute = cnt.minute + 1'b1;
      end
    end else begin
      cnt_up.second = cnt.second + 1'b1;
    end
    if (cnt.second == '0) begin
      cnt_dn.second = FMAX;
      cnt_dn.minute = cnt.minute - 1'b1;
    end else begin
      cnt_dn.second = cnt.second - 1'b1;
    end
  end

  // Prescaler, counter and one-cycle event pulses.
  always_ff @(posedge hz100) begin
    if (reset) begin
      cnt      <= '0;
      pre      <= '0;
      expired  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      expired  <= 1'b0;
      rollover <= 1'b0;
      if (clr_ev) begin
        cnt <= '0;
        pre <= '0;
      end else if (load_ok) begin
        cnt.minute <= sat_field(load_value[11:6]);
        cnt.second <= sat_field(load_value[5:0]);
        pre        <= '0;
      end else if ((state == RUNNING) && !ss_ev) begin
        if (tick) begin
          pre <= '0;
          if (mode) begin
            cnt     <= down_done ? '0 : cnt_dn;
            expired <= down_done;
          end else begin
            cnt      <= cnt_up;
            rollover <= wrap;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign counter_out = cnt;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICKS_PER_SEC = 4. Stimulus
// pushes expected snapshots tagged with the clock cycle they are due in;
// a monitor compares them against the DUT outputs on the falling edge.
module tb_stopwatch_counter;

  logic        hz100 = 1'b0;
  logic        reset, start_stop, clear, mode, load;
  logic [11:0] load_value;
  logic [11:0] counter_out;
  logic        running, expired, rollover;

  stopwatch_counter #(.TICKS_PER_SEC(4)) dut (
    .hz100(hz100), .reset(reset), .start_stop(start_stop), .clear(clear),
    .mode(mode), .load(load), .load_value(load_value),
    .counter_out(counter_out), .running(running), .expired(expired),
    .rollover(rollover)
  );

  always #5 hz100 = ~hz100;

  int cyc = 0;
  always @(posedge hz100) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    logic [11:0] cnt;
    logic        run;
    logic        ex;
    logic        ro;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_at(input int t, input string nm, input logic [11:0] c,
                           input logic r, input logic e, input logic ro);
    exp_t x;
    x.at = t; x.name = nm; x.cnt = c; x.run = r; x.ex = e; x.ro = ro;
    sb.push_back(x);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge hz100);
  endtask

  task automatic press(input logic s, input logic c, input logic l);
    start_stop = s; clear = c; load = l;
    @(negedge hz100);
    start_stop = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  initial begin
    forever begin
      @(negedge hz100);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= cyc) begin
          checks++;
          if (sb[i].at < cyc) begin
            errors++;
            $display("FAIL %s: slot missed (due cycle %0d, now %0d)", sb[i].name, sb[i].at, cyc);
          end else if (counter_out !== sb[i].cnt || running !== sb[i].run ||
                       expired !== sb[i].ex || rollover !== sb[i].ro) begin
            errors++;
            $display("FAIL %s @cycle %0d: got cnt=%h run=%b exp=%b roll=%b, want cnt=%h run=%b exp=%b roll=%b",
                     sb[i].name, cyc, counter_out, running, expired, rollover,
                     sb[i].cnt, sb[i].run, sb[i].ex, sb[i].ro);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int k;
    int guard;
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
    mode = 1'b0; load_value = 12'h000;

    expect_at(2, "reset_state", 12'h000, 0, 0, 0);
    wait_until(3);
    reset = 1'b0;

    // Count up from 00:00.
    wait_until(5); k = cyc;
    expect_at(k + 2,  "s1_not_yet",     12'h000, 0, 0, 0);
    expect_at(k + 3,  "s1_run_rise",    12'h000, 1, 0, 0);
    expect_at(k + 6,  "s1_before_step", 12'h000, 1, 0, 0);
    expect_at(k + 7,  "s1_first_step",  12'h001, 1, 0, 0);
    expect_at(k + 11, "s1_second_step", 12'h002, 1, 0, 0);
    expect_at(k + 15, "s1_clear_beats_tick", 12'h000, 0, 0, 0);
    press(1, 0, 0);
    wait_until(k + 12);
    press(0, 1, 0);

    // 00:59 -> 01:00.
    wait_until(k + 17); k = cyc;
    load_value = 12'h03B;
    expect_at(k + 3,  "s2_load_0059",   12'h03B, 0, 0, 0);
    expect_at(k + 10, "s2_pre_step",    12'h03B, 1, 0, 0);
    expect_at(k + 11, "s2_sec_carry",   12'h040, 1, 0, 0);
    expect_at(k + 14, "s2_clear",       12'h000, 0, 0, 0);
    press(0, 0, 1);
    wait_until(k + 4);  press(1, 0, 0);
    wait_until(k + 11); press(0, 1, 0);

    // 59:59 -> 00:00 with rollover.
    wait_until(k + 16); k = cyc;
    load_value = 12'hEFB;
    expect_at(k + 3,  "s2b_load_5959",  12'hEFB, 0, 0, 0);
    expect_at(k + 10, "s2b_pre_wrap",   12'hEFB, 1, 0, 0);
    expect_at(k + 11, "s2b_rollover",   12'h000, 1, 0, 1);
    expect_at(k + 12, "s2b_roll_1cyc",  12'h000, 1, 0, 0);
    expect_at(k + 15, "s2b_clear",      12'h000, 0, 0, 0);
    press(0, 0, 1);
    wait_until(k + 4);  press(1, 0, 0);
    wait_until(k + 12); press(0, 1, 0);

    // Countdown 01:00 -> 00:59.
    wait_until(k + 17); k = cyc;
    mode = 1'b1;
    load_value = 12'h040;
    expect_at(k + 3,  "s3_load_0100",   12'h040, 0, 0, 0);
    expect_at(k + 11, "s3_min_borrow",  12'h03B, 1, 0, 0);
    expect_at(k + 14, "s3_clear",       12'h000, 0, 0, 0);
    press(0, 0, 1);
    wait_until(k + 4);  press(1, 0, 0);
    wait_until(k + 11); press(0, 1, 0);

    // Countdown 00:01 -> expire, then leave EXPIRED via load.
    wait_until(k + 16); k = cyc;
    load_value = 12'h001;
    expect_at(k + 3,  "s3b_load_0001",  12'h001, 0, 0, 0);
    expect_at(k + 10, "s3b_pre_expire", 12'h001, 1, 0, 0);
    expect_at(k + 11, "s3b_expired",    12'h000, 0, 1, 0);
    expect_at(k + 12, "s3b_exp_1cyc",   12'h000, 0, 0, 0);
    expect_at(k + 31, "s3b_frozen",     12'h000, 0, 0, 0);
    expect_at(k + 35, "s3b_load_exits", 12'h005, 0, 0, 0);
    press(0, 0, 1);
    wait_until(k + 4);  press(1, 0, 0);
    wait_until(k + 32);
    mode = 1'b0;
    load_value = 12'h005;
    press(0, 0, 1);

    // Pause with prescaler at 2, hold, resume.
    wait_until(k + 37); k = cyc;
    expect_at(k + 3,  "s4_run",          12'h005, 1, 0, 0);
    expect_at(k + 6,  "s4_paused",       12'h005, 0, 0, 0);
    expect_at(k + 15, "s4_still_paused", 12'h005, 0, 0, 0);
    expect_at(k + 16, "s4_resumed",      12'h005, 1, 0, 0);
    expect_at(k + 17, "s4_resume_wait",  12'h005, 1, 0, 0);
    expect_at(k + 18, "s4_step_2_after", 12'h006, 1, 0, 0);
    expect_at(k + 22, "s5_clear_and_ss", 12'h000, 0, 0, 0);
    expect_at(k + 24, "s5_stays_idle",   12'h000, 0, 0, 0);
    press(1, 0, 0);
    wait_until(k + 3);  press(1, 0, 0);
    wait_until(k + 13); press(1, 0, 0);
    wait_until(k + 19); press(1, 1, 0);

    // Saturating load.
    wait_until(k + 25); k = cyc;
    load_value = 12'hFFC;
    expect_at(k + 3, "s5b_saturate", 12'hEFB, 0, 0, 0);
    press(0, 0, 1);

    // Reset mid-count at 12:34, start_stop held across reset release.
    wait_until(k + 5); k = cyc;
    load_value = 12'h322;
    expect_at(k + 3,  "s6_load_1234",   12'h322, 0, 0, 0);
    expect_at(k + 8,  "s6_running",     12'h322, 1, 0, 0);
    expect_at(k + 9,  "s6_reset",       12'h000, 0, 0, 0);
    expect_at(k + 14, "s6_held_no_go",  12'h000, 0, 0, 0);
    expect_at(k + 20, "s6_held_no_go2", 12'h000, 0, 0, 0);
    expect_at(k + 25, "s6_new_press",   12'h000, 1, 0, 0);
    press(0, 0, 1);
    wait_until(k + 4);  press(1, 0, 0);
    wait_until(k + 8);
    reset = 1'b1;
    start_stop = 1'b1;
    wait_until(k + 10);
    reset = 1'b0;
    wait_until(k + 20);
    start_stop = 1'b0;
    wait_until(k + 22); press(1, 0, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge hz100);
      guard++;
    end
    while (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s: never evaluated (due cycle %0d, now %0d)", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
